// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, instruction
// fields, datapath mux selects and flag bit positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ERROR    = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_GE = 3'b011;
  localparam logic [2:0] COND_LT = 3'b100;
  localparam logic [2:0] COND_GT = 3'b101;
  localparam logic [2:0] COND_LE = 3'b110;
  localparam logic [2:0] COND_CS = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is the datapath that obeys it.
interface multi_cycle_ctrl_if;
  logic       mem_ready;
  logic [1:0] op;
  logic [5:0] funct;
  logic [2:0] cond;
  logic [3:0] alu_flags;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] flags;
  logic       busy;

  modport master (
    input  mem_ready, op, funct, cond, alu_flags,
    output pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, flags, busy
  );

  modport slave (
    output mem_ready, op, funct, cond, alu_flags,
    input  pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, flags, busy
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational decode: data-processing cmd to ALU operation plus write
// suppression, and condition field evaluated against the flags register.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] cmd,
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic [2:0] alu_control,
  output logic       no_write,
  output logic       legal,
  output logic       cond_ex
);

  logic n_flag, z_flag, c_flag, v_flag;
  assign n_flag = flags[FLAG_N];
  assign z_flag = flags[FLAG_Z];
  assign c_flag = flags[FLAG_C];
  assign v_flag = flags[FLAG_V];

  always_comb begin
    alu_control = ALU_ADD;
    no_write    = 1'b0;
    legal       = 1'b1;
    case (cmd)
      CMD_ADD: alu_control = ALU_ADD;
      CMD_SUB: alu_control = ALU_SUB;
      CMD_AND: alu_control = ALU_AND;
      CMD_ORR: alu_control = ALU_ORR;
      CMD_CMP: begin
        alu_control = ALU_SUB;
        no_write    = 1'b1;
      end
      // Unknown commands still run as ADD but must leave no trace.
      default: begin
        no_write = 1'b1;
        legal    = 1'b0;
      end
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_AL: cond_ex = 1'b1;
      COND_EQ: cond_ex = z_flag;
      COND_NE: cond_ex = !z_flag;
      COND_GE: cond_ex = (n_flag == v_flag);
      COND_LT: cond_ex = (n_flag != v_flag);
      COND_GT: cond_ex = !z_flag && (n_flag == v_flag);
      COND_LE: cond_ex = z_flag || (n_flag != v_flag);
      COND_CS: cond_ex = c_flag;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle main controller: instruction FSM, NZCV flags register and
// condition-gated architectural write strobes.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  multi_cycle_ctrl_if.master  bus
);

  state_t     state_reg, state_next;
  logic [3:0] flags_reg;
  logic       cond_ex_reg;

  logic [2:0] dec_alu_control;
  logic       no_write, legal, cond_ex, flag_load;

  logic       pc_write_comb, ir_write_comb, mem_write_comb, reg_write_comb;
  logic       adr_src_comb, busy_comb;
  logic [1:0] result_src_comb, alu_src_a_comb, alu_src_b_comb;
  logic [2:0] alu_control_comb;

  ctrl_decoder u_decoder (
    .cmd         (bus.funct[4:1]),
    .cond        (bus.cond),
    .flags       (flags_reg),
    .alu_control (dec_alu_control),
    .no_write    (no_write),
    .legal       (legal),
    .cond_ex     (cond_ex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // cond_ex is frozen at DECODE so a flag update in EXEC cannot affect its own write-back.
  assign flag_load = ((state_reg == S_EXECR) || (state_reg == S_EXECI)) &&
                     bus.funct[0] && cond_ex_reg && legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_reg   <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      if (state_reg == S_DECODE) cond_ex_reg <= cond_ex;
      if (flag_load)             flags_reg   <= bus.alu_flags;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = bus.funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_next = S_BRANCH;
          OP_ILL:  state_next = S_FETCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_comb    = 1'b0;
    ir_write_comb    = 1'b0;
    mem_write_comb   = 1'b0;
    reg_write_comb   = 1'b0;
    adr_src_comb     = 1'b0;
    result_src_comb  = RES_ALUOUT;
    alu_src_a_comb   = SRCA_REG;
    alu_src_b_comb   = SRCB_REG;
    alu_control_comb = ALU_ADD;
    busy_comb        = 1'b1;
    case (state_reg)
      S_FETCH: begin
        alu_src_a_comb  = SRCA_PC;
        alu_src_b_comb  = SRCB_FOUR;
        result_src_comb = RES_ALU;
        ir_write_comb   = bus.mem_ready;
        pc_write_comb   = bus.mem_ready;
        busy_comb       = 1'b0;
      end
      S_DECODE: begin
        alu_src_a_comb = SRCA_PC;
        alu_src_b_comb = SRCB_FOUR;
      end
      S_MEMADR:   alu_src_b_comb = SRCB_IMM;
      S_MEMREAD:  adr_src_comb = 1'b1;
      S_MEMWRITE: begin
        adr_src_comb   = 1'b1;
        mem_write_comb = cond_ex_reg && bus.mem_ready;
      end
      S_MEMWB: begin
        result_src_comb = RES_MEMDATA;
        reg_write_comb  = cond_ex_reg;
      end
      S_EXECR:    alu_control_comb = dec_alu_control;
      S_EXECI: begin
        alu_src_b_comb   = SRCB_IMM;
        alu_control_comb = dec_alu_control;
      end
      S_ALUWB:    reg_write_comb = cond_ex_reg && !no_write;
      S_BRANCH: begin
        alu_src_a_comb  = SRCA_ALUOUT;
        alu_src_b_comb  = SRCB_IMM;
        result_src_comb = RES_ALU;
        pc_write_comb   = cond_ex_reg;
      end
      // Corrupted state: look exactly like FETCH under reset, strobes off.
      default: begin
        alu_src_a_comb  = SRCA_PC;
        alu_src_b_comb  = SRCB_FOUR;
        result_src_comb = RES_ALU;
        busy_comb       = 1'b0;
      end
    endcase
  end

  assign bus.pc_write    = pc_write_comb  && reset;
  assign bus.ir_write    = ir_write_comb  && reset;
  assign bus.mem_write   = mem_write_comb && reset;
  assign bus.reg_write   = reg_write_comb && reset;
  assign bus.adr_src     = adr_src_comb;
  assign bus.result_src  = result_src_comb;
  assign bus.alu_src_a   = alu_src_a_comb;
  assign bus.alu_src_b   = alu_src_b_comb;
  assign bus.alu_control = alu_control_comb;
  assign bus.flags       = flags_reg;
  assign bus.busy        = busy_comb;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expectations are queued as
// each cycle's stimulus is driven and checked against the DUT just after.
module tb_multi_cycle_ctrl;
  import ctrl_pkg::*;

  typedef struct packed {
    state_t     st;
    logic [3:0] stb;   // {pc_write, ir_write, mem_write, reg_write}
    logic [3:0] fl;
    logic [2:0] alu;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  exp_t sb[$];

  multi_cycle_ctrl_if bus();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    check("state", 8'(dut.state_reg), 8'(e.st));
    check("strobes", {4'b0, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}, {4'b0, e.stb});
    check("flags", {4'b0, bus.flags}, {4'b0, e.fl});
    check("busy", {7'b0, bus.busy}, {7'b0, (e.st != S_FETCH)});
    if (e.st inside {S_FETCH, S_DECODE, S_MEMADR, S_BRANCH, S_EXECR, S_EXECI})
      check("alu_control", {5'b0, bus.alu_control}, {5'b0, e.alu});
    if (e.st inside {S_FETCH, S_MEMREAD, S_MEMWRITE})
      check("adr_src", {7'b0, bus.adr_src}, {7'b0, (e.st != S_FETCH)});
    if (e.st == S_FETCH || e.st == S_BRANCH) check("result_src", {6'b0, bus.result_src}, {6'b0, RES_ALU});
    if (e.st == S_MEMWB) check("result_src", {6'b0, bus.result_src}, {6'b0, RES_MEMDATA});
    if (e.st == S_ALUWB) check("result_src", {6'b0, bus.result_src}, {6'b0, RES_ALUOUT});
    cyc_n++;
  endtask

  task automatic expect_now(input state_t st, input logic [3:0] stb, input logic [3:0] fl,
                            input logic [2:0] alu);
    sb.push_back('{st, stb, fl, alu});
    #1;
    compare_head();
  endtask

  task automatic cyc(input logic rdy, input state_t st, input logic [3:0] stb,
                     input logic [3:0] fl, input logic [2:0] alu);
    bus.mem_ready = rdy;
    expect_now(st, stb, fl, alu);
    @(negedge clk);
  endtask

  task automatic instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input logic [2:0] cond, input logic [3:0] af);
    bus.op        = op;
    bus.funct     = funct;
    bus.cond      = cond;
    bus.alu_flags = af;
    $display("txn %-10s op=%b funct=%b cond=%b alu_flags=%b flags=%b", name, op, funct, cond, af, bus.flags);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    instr("reset", OP_DP, 6'b001001, COND_AL, 4'b0100);
    repeat (2) @(negedge clk);
    // Strobes must stay off while held in reset even with mem_ready high.
    cyc(1, S_FETCH, 4'b0000, 4'b0000, ALU_ADD);
    reset = 1'b1;

    instr("ADDS", OP_DP, 6'b001001, COND_AL, 4'b0100);
    cyc(1, S_FETCH,  4'b1100, 4'b0000, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b0000, ALU_ADD);
    cyc(1, S_EXECR,  4'b0000, 4'b0000, ALU_ADD);
    cyc(1, S_ALUWB,  4'b0001, 4'b0100, ALU_ADD);

    instr("BNE", OP_BR, 6'b000000, COND_NE, 4'b0000);
    cyc(1, S_FETCH,  4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_BRANCH, 4'b0000, 4'b0100, ALU_ADD);

    instr("SUBS imm", OP_DP, 6'b100101, COND_AL, 4'b1000);
    cyc(0, S_FETCH,  4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_FETCH,  4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_EXECI,  4'b0000, 4'b0100, ALU_SUB);
    cyc(1, S_ALUWB,  4'b0001, 4'b1000, ALU_ADD);

    instr("CMP", OP_DP, 6'b010101, COND_AL, 4'b0100);
    cyc(1, S_FETCH,  4'b1100, 4'b1000, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b1000, ALU_ADD);
    cyc(1, S_EXECR,  4'b0000, 4'b1000, ALU_SUB);
    cyc(1, S_ALUWB,  4'b0000, 4'b0100, ALU_ADD);

    instr("BEQ", OP_BR, 6'b000000, COND_EQ, 4'b0000);
    cyc(1, S_FETCH,  4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_BRANCH, 4'b1000, 4'b0100, ALU_ADD);

    instr("illegal", OP_ILL, 6'b001001, COND_AL, 4'b1111);
    cyc(1, S_FETCH,  4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b0100, ALU_ADD);

    instr("bad cmd", OP_DP, 6'b011111, COND_AL, 4'b1111);
    cyc(1, S_FETCH,  4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE, 4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_EXECR,  4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_ALUWB,  4'b0000, 4'b0100, ALU_ADD);

    instr("LDR", OP_MEM, 6'b001001, COND_AL, 4'b0000);
    cyc(1, S_FETCH,   4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE,  4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_MEMADR,  4'b0000, 4'b0100, ALU_ADD);
    cyc(0, S_MEMREAD, 4'b0000, 4'b0100, ALU_ADD);
    cyc(0, S_MEMREAD, 4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_MEMREAD, 4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_MEMWB,   4'b0001, 4'b0100, ALU_ADD);

    instr("STR LT", OP_MEM, 6'b001000, COND_LT, 4'b0000);
    cyc(1, S_FETCH,    4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE,   4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_MEMADR,   4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_MEMWRITE, 4'b0000, 4'b0100, ALU_ADD);

    instr("STR rst", OP_MEM, 6'b001000, COND_AL, 4'b0000);
    cyc(1, S_FETCH,    4'b1100, 4'b0100, ALU_ADD);
    cyc(1, S_DECODE,   4'b0000, 4'b0100, ALU_ADD);
    cyc(1, S_MEMADR,   4'b0000, 4'b0100, ALU_ADD);
    cyc(0, S_MEMWRITE, 4'b0000, 4'b0100, ALU_ADD);
    bus.mem_ready = 1'b1;
    expect_now(S_MEMWRITE, 4'b0010, 4'b0100, ALU_ADD);
    reset = 1'b0;
    expect_now(S_FETCH, 4'b0000, 4'b0000, ALU_ADD);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, S_FETCH, 4'b0000, 4'b0000, ALU_ADD);
    cyc(1, S_FETCH, 4'b1100, 4'b0000, ALU_ADD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
